// File: rtl/uiicmp_echo_reply_tx.sv
// ICMP echo-reply transmitter: buffers the ping payload, arbitrates with the IP
// layer and streams type/code/checksum/id/seq followed by the echoed payload.
module uiicmp_echo_reply_tx #(
    parameter int unsigned BUF_AW      = 10,
    parameter logic [15:0] ACK_TIMEOUT = 16'd2000
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_icmp_req_en,
    input  logic [15:0] I_icmp_req_id,
    input  logic [15:0] I_icmp_req_sq_num,
    input  logic [15:0] I_icmp_req_checksum,
    input  logic        I_icmp_ping_echo_data_valid,
    input  logic [7:0]  I_icmp_ping_echo_data,
    input  logic [9:0]  I_icmp_ping_echo_data_len,
    output logic        O_icmp_tx_req,
    input  logic        I_icmp_tx_ack,
    output logic [15:0] O_icmp_tx_len,
    output logic        O_icmp_tx_valid,
    output logic [7:0]  O_icmp_tx_data,
    output logic        O_icmp_busy
);

    localparam int unsigned DEPTH = 1 << BUF_AW;
    localparam int unsigned PTR_W = BUF_AW + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        SEND_HDR  = 2'd2,
        SEND_DATA = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [7:0]       buf_mem [DEPTH];
    logic [7:0]       pf_byte;
    logic [PTR_W-1:0] wr_ptr;
    logic             echo_valid_d;
    logic             restart;
    logic             wr_en;
    logic [BUF_AW-1:0] wr_addr;
    logic             drop;
    logic             ovf;

    logic [15:0] id_q, sq_q, cks_q;
    logic [9:0]  len_q;
    logic [15:0] to_cnt, to_cnt_nxt;
    logic [3:0]  hdr_cnt, hdr_cnt_nxt;
    logic [15:0] rd_ptr, rd_ptr_nxt;
    logic        req_nxt, valid_nxt;
    logic [7:0]  data_nxt;
    logic [7:0]  hdr_byte;
    logic        req_accept, req_ignore;

    // Payload capture; a rising edge of the byte strobe restarts at address 0.
    assign restart = I_icmp_ping_echo_data_valid && !echo_valid_d;
    assign wr_en   = I_icmp_ping_echo_data_valid && (state == IDLE) && (restart || !wr_ptr[BUF_AW]);
    assign wr_addr = restart ? '0 : wr_ptr[BUF_AW-1:0];

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            wr_ptr       <= '0;
            echo_valid_d <= 1'b0;
            drop         <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            echo_valid_d <= I_icmp_ping_echo_data_valid;
            if (I_icmp_ping_echo_data_valid) begin
                if (state != IDLE) begin
                    drop <= 1'b1;
                end else if (restart) begin
                    wr_ptr <= PTR_W'(1);
                end else if (wr_ptr[BUF_AW]) begin
                    ovf <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
            end
            if (req_ignore) begin
                drop <= 1'b0;
                ovf  <= 1'b0;
            end
        end
    end

    // Buffer RAM; read address is the next pointer so the byte is ready a cycle early.
    always_ff @(posedge I_clk) begin
        if (wr_en) begin
            buf_mem[wr_addr] <= I_icmp_ping_echo_data;
        end
        pf_byte <= buf_mem[rd_ptr_nxt[BUF_AW-1:0]];
    end

    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_cnt[2:0])
            3'd2:    hdr_byte = cks_q[15:8];
            3'd3:    hdr_byte = cks_q[7:0];
            3'd4:    hdr_byte = id_q[15:8];
            3'd5:    hdr_byte = id_q[7:0];
            3'd6:    hdr_byte = sq_q[15:8];
            3'd7:    hdr_byte = sq_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_nxt     = O_icmp_tx_req;
        valid_nxt   = 1'b0;
        data_nxt    = 8'h00;
        hdr_cnt_nxt = hdr_cnt;
        rd_ptr_nxt  = rd_ptr;
        to_cnt_nxt  = to_cnt;
        req_accept  = 1'b0;
        req_ignore  = 1'b0;
        case (state)
            IDLE: begin
                if (I_icmp_req_en) begin
                    if (drop || ovf || (I_icmp_ping_echo_data_len == 10'd0)) begin
                        req_ignore = 1'b1;
                    end else begin
                        req_accept = 1'b1;
                        req_nxt    = 1'b1;
                        to_cnt_nxt = 16'd0;
                        state_nxt  = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (I_icmp_tx_ack && O_icmp_tx_req) begin
                    req_nxt     = 1'b0;
                    valid_nxt   = 1'b1;
                    data_nxt    = 8'h00;
                    hdr_cnt_nxt = 4'd1;
                    rd_ptr_nxt  = 16'd0;
                    state_nxt   = SEND_HDR;
                end else if ((17'(to_cnt) + 17'd1) >= 17'(ACK_TIMEOUT)) begin
                    req_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else if (to_cnt != 16'hFFFF) begin
                    to_cnt_nxt = to_cnt + 16'd1;
                end
            end
            SEND_HDR: begin
                valid_nxt = 1'b1;
                if (hdr_cnt == 4'd8) begin
                    data_nxt   = pf_byte;
                    rd_ptr_nxt = rd_ptr + 16'd1;
                    state_nxt  = SEND_DATA;
                end else begin
                    data_nxt    = hdr_byte;
                    hdr_cnt_nxt = hdr_cnt + 4'd1;
                end
            end
            SEND_DATA: begin
                if (rd_ptr == 16'(len_q)) begin
                    state_nxt = IDLE;
                end else begin
                    valid_nxt  = 1'b1;
                    data_nxt   = pf_byte;
                    rd_ptr_nxt = rd_ptr + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs and per-request context.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            O_icmp_tx_req   <= 1'b0;
            O_icmp_tx_valid <= 1'b0;
            O_icmp_tx_data  <= 8'h00;
            O_icmp_tx_len   <= 16'd0;
            O_icmp_busy     <= 1'b0;
            hdr_cnt         <= 4'd0;
            rd_ptr          <= 16'd0;
            to_cnt          <= 16'd0;
            id_q            <= 16'd0;
            sq_q            <= 16'd0;
            cks_q           <= 16'd0;
            len_q           <= 10'd0;
        end else begin
            O_icmp_tx_req   <= req_nxt;
            O_icmp_tx_valid <= valid_nxt;
            O_icmp_tx_data  <= data_nxt;
            O_icmp_busy     <= (state_nxt != IDLE);
            hdr_cnt         <= hdr_cnt_nxt;
            rd_ptr          <= rd_ptr_nxt;
            to_cnt          <= to_cnt_nxt;
            if (req_accept) begin
                id_q          <= I_icmp_req_id;
                sq_q          <= I_icmp_req_sq_num;
                cks_q         <= I_icmp_req_checksum;
                len_q         <= I_icmp_ping_echo_data_len;
                O_icmp_tx_len <= 16'(I_icmp_ping_echo_data_len) + 16'd8;
            end
        end
    end

endmodule

// File: tb/tb_uiicmp_echo_reply_tx.sv
// Directed bench for uiicmp_echo_reply_tx: frame content, arbitration, timeout,
// drop/overflow rejection and mid-stream reset.
module tb_uiicmp_echo_reply_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_en;
    logic [15:0] req_id, req_sq, req_cks;
    logic        dv;
    logic [7:0]  dd;
    logic [9:0]  dlen;
    logic        tx_req, tx_ack, tx_valid, busy;
    logic [15:0] tx_len;
    logic [7:0]  tx_data;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    uiicmp_echo_reply_tx dut (
        .I_clk                       (clk),
        .I_reset                     (rst),
        .I_icmp_req_en               (req_en),
        .I_icmp_req_id               (req_id),
        .I_icmp_req_sq_num           (req_sq),
        .I_icmp_req_checksum         (req_cks),
        .I_icmp_ping_echo_data_valid (dv),
        .I_icmp_ping_echo_data       (dd),
        .I_icmp_ping_echo_data_len   (dlen),
        .O_icmp_tx_req               (tx_req),
        .I_icmp_tx_ack               (tx_ack),
        .O_icmp_tx_len               (tx_len),
        .O_icmp_tx_valid             (tx_valid),
        .O_icmp_tx_data              (tx_data),
        .O_icmp_busy                 (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_burst(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            dv = 1'b1;
            dd = base + 8'(i);
            @(negedge clk);
        end
        dv = 1'b0;
        dd = 8'h00;
    endtask

    task automatic send_req(input logic [15:0] id, input logic [15:0] sq,
                            input logic [15:0] cks, input logic [9:0] len);
        req_en  = 1'b1;
        req_id  = id;
        req_sq  = sq;
        req_cks = cks;
        dlen    = len;
        @(negedge clk);
        req_en  = 1'b0;
    endtask

    task automatic build_exp(input logic [15:0] cks, input logic [15:0] id,
                             input logic [15:0] sq, input int n, input logic [7:0] base);
        exp_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(cks[15:8]);
        exp_q.push_back(cks[7:0]);
        exp_q.push_back(id[15:8]);
        exp_q.push_back(id[7:0]);
        exp_q.push_back(sq[15:8]);
        exp_q.push_back(sq[7:0]);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 8'(i));
    endtask

    // Waits for req (bounded), grants after 'delay' cycles, checks the handover.
    task automatic do_ack(input int delay);
        int n = 0;
        while (tx_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 32'(tx_req), 1);
        repeat (delay) @(negedge clk);
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
        chk("req_fall", 32'(tx_req), 0);
        chk("first_valid", 32'(tx_valid), 1);
    endtask

    task automatic collect_frame();
        int n = 0;
        rx_q.delete();
        while (tx_valid === 1'b1 && n < 2000) begin
            rx_q.push_back(tx_data);
            n++;
            @(negedge clk);
        end
        chk("idle_data", 32'(tx_data), 0);
    endtask

    task automatic check_frame(input string name);
        int m;
        chk({name, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        m = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            chk($sformatf("%s_b%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int cnt;
        logic seen;
        rst = 1'b1; req_en = 1'b0; req_id = '0; req_sq = '0; req_cks = '0;
        dv = 1'b0; dd = '0; dlen = '0; tx_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(tx_req), 0);
        chk("rst_valid", 32'(tx_valid), 0);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_len", 32'(tx_len), 0);

        // 32-byte payload, ack 3 cycles after req, stray req_en/ack during the header
        send_burst(32, 8'h00);
        @(negedge clk);
        send_req(16'h1234, 16'h0001, 16'hA5C3, 10'd32);
        chk("t1_req", 32'(tx_req), 1);
        chk("t1_txlen", 32'(tx_len), 40);
        chk("t1_busy", 32'(busy), 1);
        do_ack(3);
        build_exp(16'hA5C3, 16'h1234, 16'h0001, 32, 8'h00);
        fork
            collect_frame();
            begin
                repeat (2) @(negedge clk);
                req_en = 1'b1; req_id = 16'hFFFF; req_sq = 16'hFFFF; req_cks = 16'hFFFF; dlen = 10'd5;
                tx_ack = 1'b1;
                @(negedge clk);
                req_en = 1'b0; tx_ack = 1'b0;
            end
        join
        check_frame("t1");
        @(negedge clk);
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_no_req", 32'(tx_req), 0);

        // single-byte payload
        send_burst(1, 8'hEE);
        send_req(16'hBEEF, 16'h0002, 16'h1357, 10'd1);
        chk("t2_txlen", 32'(tx_len), 9);
        do_ack(0);
        build_exp(16'h1357, 16'hBEEF, 16'h0002, 1, 8'hEE);
        collect_frame();
        check_frame("t2");
        @(negedge clk);
        chk("t2_busy_end", 32'(busy), 0);

        // no ack: req held ACK_TIMEOUT cycles, nothing sent, then a retry completes
        send_burst(4, 8'h10);
        send_req(16'h5555, 16'h0005, 16'h1111, 10'd4);
        cnt = 0; seen = 1'b0;
        while (tx_req === 1'b1 && cnt < 3000) begin
            if (tx_valid) seen = 1'b1;
            cnt++;
            @(negedge clk);
        end
        chk("t3_req_cycles", 32'(cnt), 2000);
        chk("t3_no_valid", 32'(seen), 0);
        chk("t3_busy", 32'(busy), 0);
        send_req(16'h5555, 16'h0005, 16'h1111, 10'd4);
        do_ack(2);
        build_exp(16'h1111, 16'h5555, 16'h0005, 4, 8'h10);
        collect_frame();
        check_frame("t3");

        // second burst lands during SEND_DATA: frame intact, its request dropped
        send_burst(16, 8'h40);
        send_req(16'hAAAA, 16'h0003, 16'h0F0F, 10'd16);
        do_ack(1);
        build_exp(16'h0F0F, 16'hAAAA, 16'h0003, 16, 8'h40);
        fork
            collect_frame();
            begin
                repeat (10) @(negedge clk);
                send_burst(4, 8'h99);
            end
        join
        check_frame("t4a");
        @(negedge clk);
        send_req(16'h0BAD, 16'h0BAD, 16'h0BAD, 10'd4);
        seen = 1'b0;
        repeat (6) begin
            if (tx_req || busy) seen = 1'b1;
            @(negedge clk);
        end
        chk("t4_dropped", 32'(seen), 0);
        send_burst(3, 8'h70);
        send_req(16'h0102, 16'h0004, 16'hBEEF, 10'd3);
        do_ack(0);
        build_exp(16'hBEEF, 16'h0102, 16'h0004, 3, 8'h70);
        collect_frame();
        check_frame("t4c");

        // 1025-byte payload overflows the 1024-byte buffer: request ignored
        send_burst(1025, 8'h00);
        send_req(16'h7777, 16'h0006, 16'h2222, 10'(1025));
        seen = 1'b0;
        repeat (8) begin
            if (tx_req || busy) seen = 1'b1;
            @(negedge clk);
        end
        chk("t5_ignored", 32'(seen), 0);

        // asynchronous reset on byte 5 of the stream, then a clean frame
        send_burst(8, 8'h80);
        send_req(16'h3333, 16'h0007, 16'h4444, 10'd8);
        do_ack(1);
        repeat (5) @(negedge clk);
        chk("t6_pre_valid", 32'(tx_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(tx_valid), 0);
        chk("t6_rst_data", 32'(tx_data), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_len", 32'(tx_len), 0);
        chk("t6_rst_req", 32'(tx_req), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_burst(5, 8'hC0);
        send_req(16'h6666, 16'h0008, 16'h9999, 10'd5);
        do_ack(2);
        build_exp(16'h9999, 16'h6666, 16'h0008, 5, 8'hC0);
        collect_frame();
        check_frame("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
